// File: rtl/db_ram_rd_ctrl_if.sv
// Bus bundle for the deblocking RAM read controller: RAM read port plus the
// valid/ready output stream. master = controller side, slave = RAM + consumer.
interface db_ram_rd_ctrl_if #(
  parameter int unsigned Word_Width = 128,
  parameter int unsigned Addr_Width = 8
);
  logic                  ram_cen_o;
  logic                  ram_oen_o;
  logic                  ram_wen_o;
  logic [Addr_Width-1:0] ram_addr_o;
  logic [Word_Width-1:0] ram_data_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [Word_Width-1:0] data_o;

  modport master (
    output ram_cen_o, ram_oen_o, ram_wen_o, ram_addr_o,
    input  ram_data_i,
    output valid_o, data_o,
    input  ready_i
  );

  modport slave (
    input  ram_cen_o, ram_oen_o, ram_wen_o, ram_addr_o,
    output ram_data_i,
    input  valid_o, data_o,
    output ready_i
  );
endinterface

// File: rtl/db_ram_rd_ctrl.sv
// Streams a wrapping range of RAM words to a valid/ready consumer, using a
// 2-entry buffer to hide the 1-cycle RAM read latency at full throughput.
module db_ram_rd_ctrl #(
  parameter int unsigned Word_Width = 128,
  parameter int unsigned Addr_Width = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [Addr_Width-1:0] base_addr_i,
  input  logic [Addr_Width:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  db_ram_rd_ctrl_if.master      bus
);

  localparam int unsigned LenW = Addr_Width + 1;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [Addr_Width-1:0] base_q, base_d;
  logic [LenW-1:0]       len_q, len_d;
  logic [LenW-1:0]       issued_q, issued_d;
  logic [LenW-1:0]       popped_q, popped_d;
  logic                  inflight_q;
  logic [Word_Width-1:0] buf_q [2];
  logic [Word_Width-1:0] buf_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;

  logic       issue;
  logic       pop;
  logic       valid;
  logic [2:0] occ;

  assign valid = (buf_cnt_q != 2'd0);
  assign pop   = valid & bus.ready_i;
  // Words already owned (buffered + in flight) after this cycle's pop.
  assign occ   = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == StRead) && (issued_q != len_q) && (occ < 3'd2);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q + {{Addr_Width{1'b0}}, issue};
    popped_d = popped_q + {{Addr_Width{1'b0}}, pop};
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d   = base_addr_i;
          len_d    = len_i;
          issued_d = '0;
          popped_d = '0;
          state_d  = (len_i == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        if (issue && (issued_q + LenW'(1) == len_q)) state_d = StDrain;
      end
      StDrain: begin
        if (pop && (popped_q + LenW'(1) == len_q)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // RAM data lands the cycle after issue, so the in-flight flag is the push.
  always_comb begin
    buf_d     = buf_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    buf_cnt_d = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    if (inflight_q) begin
      buf_d[wr_ptr_q] = bus.ram_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      buf_cnt_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= issue;
      buf_q      <= buf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      buf_cnt_q  <= buf_cnt_d;
    end
  end

  assign busy_o         = (state_q != StIdle);
  assign done_o         = (state_q == StDone);
  assign bus.ram_cen_o  = ~issue;
  assign bus.ram_oen_o  = ~issue;
  assign bus.ram_wen_o  = 1'b1;
  assign bus.ram_addr_o = base_q + issued_q[Addr_Width-1:0];
  assign bus.valid_o    = valid;
  assign bus.data_o     = buf_q[rd_ptr_q];

endmodule
